// File: rtl/serial_paralelo_rx_if.sv
// Serial receive bus: one serial bit in, aligned byte stream and link status out.
interface serial_paralelo_rx_if #(
  parameter int WIDTH = 8
) ();
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;

  // Bit source side: drives the serial line, observes the recovered bytes.
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  // Receiver side.
  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with comma-based byte alignment.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   SEARCH | compare every bit offset against COMMA, bit counter held at 0
//   ALIGN  | candidate alignment found, counting consecutive boundary commas
//   ACTIVE | link locked (sticky), data bytes emitted at each boundary
module serial_paralelo_rx #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  serial_paralelo_rx_if.slave  bus
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW   = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);
  localparam logic [CW-1:0]   LOCK_M1  = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0]   LOCK_MAX = CW'(LOCK_COUNT);
  localparam logic [CW-1:0]   ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] sr_q,        sr_d;
  logic [CNTW-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
  logic [WIDTH-1:0] data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             active_q,    active_d;

  logic [WIDTH-1:0] nxt;
  logic             boundary;
  logic             is_comma;

  // Next-state: shift register, bit phase, comma counting and output capture.
  always_comb begin
    nxt         = {sr_q[WIDTH-2:0], bus.data_in};
    boundary    = (bit_cnt_q == BIT_LAST);
    is_comma    = (nxt == COMMA);
    sr_d        = nxt;
    state_d     = state_q;
    bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    active_d    = active_q;

    case (state_q)
      SEARCH: begin
        // Phase is meaningless until a comma anchors it.
        bit_cnt_d = '0;
        if (is_comma) begin
          comma_cnt_d = ONE_CNT;
          if (LOCK_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            if (comma_cnt_q == LOCK_M1) begin
              comma_cnt_d = LOCK_MAX;
              state_d     = ACTIVE;
              active_d    = 1'b1;
            end else begin
              comma_cnt_d = comma_cnt_q + 1'b1;
            end
          end else begin
            // The offending byte is dropped; search restarts from the next bit.
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        if (boundary) begin
          if (is_comma) begin
            data_d  = '0;
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = SEARCH;
        bit_cnt_d   = '0;
        comma_cnt_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears outputs without a clock edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed scenarios plus random traffic,
// every cycle compared against a bit-stream reference model.
module tb_serial_paralelo_rx;

  localparam int         W  = 8;
  localparam logic [7:0] BC = 8'hBC;
  localparam int         LC = 4;

  logic clk;
  logic reset_L;

  serial_paralelo_rx_if #(.WIDTH(W)) bus ();

  serial_paralelo_rx #(
    .WIDTH(W), .COMMA(BC), .LOCK_COUNT(LC)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_bits   = 0;

  // Reference model: link phase described by how many bits have passed since
  // the last alignment anchor and how many aligned commas were seen.
  int         m_mode;     // 0 hunting, 1 counting commas, 2 locked
  int         m_phase;    // bits since the anchor, modulo W
  int         m_commas;
  logic [7:0] m_hist;     // last W received bits
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_active;

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_commas = 0; m_hist = 8'h00;
    m_dout = 8'h00; m_valid = 1'b0; m_active = 1'b0;
  endfunction

  function automatic void model_bit(input logic b);
    logic [7:0] byte_now;
    bit         at_boundary;
    byte_now    = {m_hist[6:0], b};
    m_hist      = byte_now;
    at_boundary = (m_phase == W - 1);
    if (m_mode == 0) begin
      m_phase = 0;
      if (byte_now == BC) begin
        m_commas = 1;
        m_mode   = (LC == 1) ? 2 : 1;
        if (m_mode == 2) m_active = 1'b1;
      end
    end else begin
      m_phase = (m_phase + 1) % W;
      if (at_boundary && m_mode == 1) begin
        if (byte_now == BC) begin
          m_commas++;
          if (m_commas == LC) begin
            m_mode   = 2;
            m_active = 1'b1;
          end
        end else begin
          m_commas = 0;
          m_mode   = 0;
        end
      end else if (at_boundary && m_mode == 2) begin
        m_valid = (byte_now != BC);
        m_dout  = m_valid ? byte_now : 8'h00;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (bit %0d, t=%0t)", tag, got, exp, n_bits, $time);
    end
  endtask

  task automatic check_outputs();
    chk("data_out",  32'(bus.data_out),  32'(m_dout));
    chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
    chk("active",    32'(bus.active),    32'(m_active));
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.data_in = b;
    @(posedge clk);
    model_bit(b);
    n_bits++;
    #1;
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Assert reset between clock edges and check that outputs clear at once.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk({tag, "_data"},   32'(bus.data_out),  32'h0);
    chk({tag, "_valid"},  32'(bus.valid_out), 32'h0);
    chk({tag, "_active"}, 32'(bus.active),    32'h0);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  int         start_bit;
  int         rise_bit;
  int         valid_run;
  logic [7:0] rb;

  initial begin
    reset_L     = 1'b0;
    bus.data_in = 1'b0;
    model_reset();
    #2;
    chk("reset_data",   32'(bus.data_out),  32'h0);
    chk("reset_valid",  32'(bus.valid_out), 32'h0);
    chk("reset_active", 32'(bus.active),    32'h0);
    @(negedge clk);
    reset_L = 1'b1;

    // Lock and first data: 3 junk bits, 4 commas, 5A, FF.
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    start_bit = n_bits;
    rise_bit  = -1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(BC[i]);
        if (rise_bit < 0 && bus.active === 1'b1) rise_bit = n_bits;
      end
    end
    chk("lock_bit_position", 32'(rise_bit - start_bit), 32'd32);
    send_byte(8'h5A);
    chk("first_byte", 32'(bus.data_out), 32'h5A);
    send_byte(8'hFF);
    chk("second_byte", 32'(bus.data_out), 32'hFF);

    // Mid-byte reset while data is flowing.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    async_reset("midbyte_reset");

    // Broken lock sequence, then a clean one.
    for (int k = 0; k < 3; k++) send_byte(BC);
    send_byte(8'h11);
    chk("broken_lock_active", 32'(bus.active), 32'h0);
    for (int k = 0; k < 4; k++) send_byte(BC);
    chk("relock_active", 32'(bus.active), 32'h1);
    send_byte(8'h22);
    chk("relock_data", 32'(bus.data_out), 32'h22);

    // Idle comma between data bytes.
    send_byte(8'h33);
    chk("idle_pre_valid", 32'(bus.valid_out), 32'h1);
    send_byte(BC);
    chk("idle_valid", 32'(bus.valid_out), 32'h0);
    chk("idle_data",  32'(bus.data_out),  32'h0);
    send_byte(8'h44);
    chk("idle_post_data", 32'(bus.data_out), 32'h44);
    chk("idle_active",    32'(bus.active),   32'h1);

    // Back-to-back data 00..07: valid must stay high for all 64 bits.
    valid_run = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(k[i]);
        if (bus.valid_out === 1'b1) valid_run++;
      end
    end
    chk("b2b_valid_run", 32'(valid_run), 32'd64);
    chk("b2b_last",      32'(bus.data_out), 32'h07);

    // False comma at a 4-bit offset.
    async_reset("pre_offset_reset");
    send_byte(8'h0B);
    send_byte(8'hC0);
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(BC);
    chk("offset_lock", 32'(bus.active), 32'h1);
    send_byte(8'hA5);
    chk("offset_data", 32'(bus.data_out), 32'hA5);

    // Random traffic: random junk, possibly broken lock, then mixed data/commas.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) async_reset("rand_reset");
      for (int j = 0; j < int'($urandom_range(0, 9)); j++) send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_byte(BC);
        send_byte(8'h5E);
      end
      for (int k = 0; k < 4; k++) send_byte(BC);
      for (int k = 0; k < 12; k++) begin
        rb = ($urandom_range(0, 4) == 0) ? BC : 8'($urandom);
        send_byte(rb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
